// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI master sequencer and its round-robin arbiter.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE,
        ST_DONE
    } seq_state_t;

    localparam int NUM_REQ    = 2;
    localparam int REQ_HOST   = 0;
    localparam int REQ_POLL   = 1;
    localparam int BUSY_GRACE = 4;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arbiter2
    import spi_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic last_q;

    always_comb begin
        grant_idx = 1'(REQ_HOST);
        grant     = '0;
        if (req[0] && req[1]) begin
            // Contention goes to whoever was not served last.
            grant_idx = ~last_q;
        end else if (req[1]) begin
            grant_idx = 1'(REQ_POLL);
        end
        if (|req) begin
            grant = req_onehot(grant_idx);
        end
    end

    // Pointer starts on the poll engine so the host path wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'(REQ_POLL);
        end else if (accept && (|req)) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/spi_master_sequencer.sv
// Arbitrates two transfer requesters onto one SPI master core and sequences
// load / start / completion handshakes with a watchdog timeout.
module spi_master_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5,
    parameter int CS_W   = 1,
    parameter int TMO_W  = 12
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_data,
    input  logic [2*LEN_W-1:0]  req_len,
    input  logic [2*CS_W-1:0]   req_cs,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_tmo,
    output logic                m_start,
    output logic [DATA_W-1:0]   m_mosi,
    output logic [LEN_W-1:0]    m_len,
    output logic [CS_W-1:0]     m_cs,
    input  logic                m_writable,
    input  logic                m_idle,
    input  logic [DATA_W-1:0]   m_miso,
    output logic                busy
);

    localparam int              GW         = $clog2(BUSY_GRACE);
    localparam logic [GW-1:0]   GRACE_LAST = GW'(BUSY_GRACE - 1);
    localparam logic [TMO_W-1:0] TMO_MAX   = '1;

    seq_state_t       state, state_next;
    logic [1:0]       grant;
    logic             grant_idx;
    logic             take_grant;
    logic             owner_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GW-1:0]    grace_cnt;
    logic             tmo_hit;
    logic             completed;

    assign take_grant = (state == ST_IDLE) && (|req_valid);
    assign tmo_hit    = (tmo_cnt == TMO_MAX);
    assign completed  = (state == ST_WAIT_IDLE) && m_idle;

    rr_arbiter2 u_arb (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .req       (req_valid),
        .accept    (take_grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Accept strobe is only meaningful in IDLE and is held off while reset is applied.
    assign req_ready = (sys_rst_n && (state == ST_IDLE)) ? grant : 2'b00;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (|req_valid) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (m_writable)   state_next = ST_START;
                else if (tmo_hit) state_next = ST_DONE;
            end
            ST_START: begin
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A core faster than our sampling never shows busy; fall through after the grace window.
                if (!m_idle || (grace_cnt == GRACE_LAST)) state_next = ST_WAIT_IDLE;
                else if (tmo_hit)                         state_next = ST_DONE;
            end
            ST_WAIT_IDLE: begin
                if (m_idle || tmo_hit) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            owner_q   <= 1'b0;
            m_start   <= 1'b0;
            m_mosi    <= '0;
            m_len     <= '0;
            m_cs      <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_tmo   <= 1'b0;
            tmo_cnt   <= '0;
            grace_cnt <= '0;
        end else begin
            state   <= state_next;
            busy    <= (state_next != ST_IDLE);
            m_start <= (state == ST_START);

            // Granted fields are captured once; later req_* changes are ignored.
            if (take_grant) begin
                owner_q <= grant_idx;
                m_mosi  <= grant_idx ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
                m_len   <= grant_idx ? req_len[2*LEN_W-1:LEN_W]    : req_len[LEN_W-1:0];
                m_cs    <= grant_idx ? req_cs[2*CS_W-1:CS_W]       : req_cs[CS_W-1:0];
            end

            if ((state == ST_IDLE) || (state == ST_START)) begin
                tmo_cnt <= '0;
            end else if (((state == ST_LOAD) || (state == ST_WAIT_BUSY) ||
                          (state == ST_WAIT_IDLE)) && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (state == ST_START) begin
                grace_cnt <= '0;
            end else if ((state == ST_WAIT_BUSY) && m_idle) begin
                grace_cnt <= grace_cnt + 1'b1;
            end

            // Response registers load on the edge entering DONE so they are visible during DONE.
            if ((state_next == ST_DONE) && (state != ST_DONE)) begin
                rsp_valid <= req_onehot(owner_q);
                rsp_tmo   <= !completed;
                rsp_data  <= completed ? m_miso : '0;
            end else begin
                rsp_valid <= '0;
                rsp_tmo   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_master_sequencer.md
SPI_MASTER_SEQUENCER -- requirements
Module: spi_master_sequencer

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 16, SPI word width; LEN_W, 5, length field width (value = bits-1); CS_W, 1, chip-select vector width; TMO_W, 12, timeout counter width.
REQ-002 sys_clk  in  1  single system clock, all logic on rising edge.
REQ-003 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  2  transfer request; bit0 = host register path, bit1 = autonomous poll engine.
REQ-005 req_ready  out  2  one-hot accept strobe, one cycle, to the granted requester.
REQ-006 req_data / req_len / req_cs  in  2*DATA_W / 2*LEN_W / 2*CS_W  per-requester MOSI word, length-1, CS select; requester i in slice i.
REQ-007 rsp_valid  out  2  one-cycle completion strobe to the owning requester.
REQ-008 rsp_data  out  DATA_W  captured MISO word, valid with rsp_valid.
REQ-009 rsp_tmo  out  1  completion flag: transfer aborted by timeout, valid with rsp_valid.
REQ-010 m_start  out  1  one-cycle load/start pulse to the SPI master core.
REQ-011 m_mosi / m_len / m_cs  out  DATA_W / LEN_W / CS_W  word, length, CS to master core; stable from start until completion.
REQ-012 m_writable / m_idle  in  1 / 1  master core status.
REQ-013 m_miso  in  DATA_W  master core receive word.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_IDLE, DONE.
REQ-016 IDLE: on any req_valid, grant one requester, pulse its req_ready, latch its data/len/cs, go to LOAD the next cycle.
REQ-017 Arbitration: round-robin; on simultaneous requests, grant the requester not granted last; after reset, requester 0 has priority.
REQ-018 LOAD: drive latched fields on m_mosi/m_len/m_cs; go to START when m_writable=1, else stay.
REQ-019 START: assert m_start for exactly one cycle; go to WAIT_BUSY.
REQ-020 WAIT_BUSY: go to WAIT_IDLE on m_idle=0; if m_idle stays 1 for 4 cycles, go to WAIT_IDLE anyway (the transfer completed faster than sampling).
REQ-021 WAIT_IDLE: on m_idle=1, capture m_miso into rsp_data and go to DONE.
REQ-022 DONE: pulse rsp_valid[owner] for one cycle with rsp_tmo; go to IDLE; a new grant is possible on the following cycle.
REQ-023 Timeout: counter cleared in START, increments in LOAD/WAIT_BUSY/WAIT_IDLE; at all-ones, go to DONE with rsp_tmo=1 and rsp_data=0.
REQ-024 Request-to-m_start latency: 3 cycles when m_writable=1.
REQ-025 req_valid deasserting while not granted is legal and causes no grant; the latched fields of a granted request ignore later req_* changes.
REQ-026 m_len forwards the latched length unchanged (value = bits-1, e.g. 15 for 16-bit words).

Reset
REQ-027 On sys_rst_n=0: state IDLE; req_ready, rsp_valid, rsp_tmo, m_start, busy = 0; rsp_data, m_mosi, m_len, m_cs, timeout counter = 0; round-robin pointer favours requester 0.
REQ-028 Reset mid-transfer aborts without a response; m_start must never glitch during or after reset release.

Structure
REQ-029 Shared package spi_seq_pkg holds the state enum, requester index constants (REQ_HOST=0, REQ_POLL=1) and the WAIT_BUSY grace constant (4).
REQ-030 The round-robin arbiter is one sub-module, rr_arbiter2, combinational grant plus registered last-grant pointer; the rest is flat.

Verification
REQ-031 Single host request data=0xAA55, len=15, cs=1, model core idle after 20 cycles -> req_ready[0] pulse, m_start 3 cycles later with m_mosi=0xAA55, then rsp_valid[0] with the model's MISO word, rsp_tmo=0.
REQ-032 Both requesters valid in the same cycle, twice in succession -> grants 0, 1, 0, 1; exactly one req_ready bit high per grant.
REQ-033 m_writable held low for 50 cycles -> no m_start; after it rises, m_start within 1 cycle of leaving LOAD; data 0x8000 delivered intact.
REQ-034 Model core never returns m_idle=1 -> rsp_valid with rsp_tmo=1, rsp_data=0 after 4095 cycles; next request serviced normally.
REQ-035 m_idle never drops (zero-latency core) -> DONE reached through the 4-cycle grace path; rsp_data=m_miso (0x5555).
REQ-036 sys_rst_n asserted in WAIT_IDLE -> all outputs 0 immediately, no rsp_valid; after release, requester 0 wins a simultaneous request.
